// File: rtl/memory_access_stage_if.sv
// Data-memory request/response bus between the M stage and data memory.
// The M stage is the master: it issues req/we/addr/wdata/wstrb and
// receives ready (request accepted) and rvalid/rdata (load data return).
interface memory_access_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ready;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/memory_access_stage.sv
// M stage of the 5-stage RV32I pipeline. Latches E-stage results, issues
// one data-memory access per aligned load/store, stalls upstream until the
// access completes and delivers aligned/extended load data to W.
module memory_access_stage #(
    parameter int         XLEN     = 32,
    parameter logic [6:0] OP_LOAD  = 7'h03,
    parameter logic [6:0] OP_STORE = 7'h23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            e_to_m_valid,
    output logic            m_allow_in,
    output logic            m_to_w_valid,
    input  logic            w_allow_in,
    input  logic [6:0]      E_opcode,
    input  logic [2:0]      E_funct3,
    input  logic [4:0]      E_rd,
    input  logic [XLEN-1:0] E_valE,
    input  logic [XLEN-1:0] E_valB,
    input  logic [XLEN-1:0] E_default_pc,
    input  logic [XLEN-1:0] E_cur_pc,
    input  logic [XLEN-1:0] E_instr,
    input  logic [XLEN-1:0] E_pred_pc,
    output logic [6:0]      M_opcode,
    output logic [4:0]      M_rd,
    output logic [XLEN-1:0] M_valE,
    output logic [XLEN-1:0] M_default_pc,
    output logic [XLEN-1:0] M_cur_pc,
    output logic [XLEN-1:0] M_instr,
    output logic [XLEN-1:0] M_pred_pc,
    output logic [XLEN-1:0] m_valM,
    output logic            M_misalign,
    memory_access_stage_if.master dmem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic            m_valid;
    logic            m_mem;      // aligned memory op held in M
    logic            m_store;
    logic [2:0]      M_funct3;
    logic [XLEN-1:0] M_valB;
    logic            m_ready_go;
    logic            capture;
    logic            e_load, e_store, e_misalign, e_mem_go;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_ext;

    assign e_load     = (E_opcode == OP_LOAD);
    assign e_store    = (E_opcode == OP_STORE);
    assign e_misalign = (e_load | e_store) &
                        (((E_funct3[1:0] == 2'b01) & E_valE[0]) |
                         ((E_funct3[1:0] == 2'b10) & (E_valE[1:0] != 2'b00)));
    assign e_mem_go   = (e_load | e_store) & ~e_misalign;

    assign m_ready_go   = ~m_mem | (state == DONE);
    assign m_allow_in   = ~m_valid | (m_ready_go & w_allow_in);
    assign m_to_w_valid = m_valid & m_ready_go;
    assign capture      = m_allow_in & e_to_m_valid;

    // Pipeline register: valid bit, E-stage fields and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_mem        <= 1'b0;
            m_store      <= 1'b0;
            M_funct3     <= '0;
            M_valB       <= '0;
            M_opcode     <= '0;
            M_rd         <= '0;
            M_valE       <= '0;
            M_default_pc <= '0;
            M_cur_pc     <= '0;
            M_instr      <= '0;
            M_pred_pc    <= '0;
            M_misalign   <= 1'b0;
            m_valM       <= '0;
        end else begin
            if (m_allow_in) begin
                m_valid <= e_to_m_valid;
            end
            if (capture) begin
                m_mem        <= e_mem_go;
                m_store      <= e_store;
                M_funct3     <= E_funct3;
                M_valB       <= E_valB;
                M_opcode     <= E_opcode;
                M_rd         <= E_rd;
                M_valE       <= E_valE;
                M_default_pc <= E_default_pc;
                M_cur_pc     <= E_cur_pc;
                M_instr      <= E_instr;
                M_pred_pc    <= E_pred_pc;
                M_misalign   <= e_misalign;
                m_valM       <= '0;
            end else if ((state == WAIT) && dmem.dmem_rvalid) begin
                m_valM <= load_ext;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: access progress, overridden whenever a new instruction enters
    always_comb begin
        state_next = state;
        case (state)
            REQ:     if (dmem.dmem_ready) state_next = m_store ? DONE : WAIT;
            WAIT:    if (dmem.dmem_rvalid) state_next = DONE;
            default: state_next = state;
        endcase
        if (m_allow_in) begin
            state_next = (e_to_m_valid && e_mem_go) ? REQ : IDLE;
        end
    end

    // Load data lane selection and sign/zero extension
    always_comb begin
        ld_byte  = '0;
        ld_half  = '0;
        load_ext = '0;
        case (M_valE[1:0])
            2'b00:   ld_byte = dmem.dmem_rdata[7:0];
            2'b01:   ld_byte = dmem.dmem_rdata[15:8];
            2'b10:   ld_byte = dmem.dmem_rdata[23:16];
            default: ld_byte = dmem.dmem_rdata[31:24];
        endcase
        ld_half = M_valE[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (M_funct3)
            3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  load_ext = dmem.dmem_rdata;
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: load_ext = '0;
        endcase
    end

    // Request outputs, held stable from registered M state while in REQ
    always_comb begin
        dmem.dmem_req   = (state == REQ);
        dmem.dmem_we    = m_store;
        dmem.dmem_addr  = {M_valE[XLEN-1:2], 2'b00};
        dmem.dmem_wdata = M_valB;
        dmem.dmem_wstrb = '0;
        if (m_store) begin
            case (M_funct3[1:0])
                2'b00: begin
                    dmem.dmem_wstrb = 4'b0001 << M_valE[1:0];
                    dmem.dmem_wdata = {(XLEN/8){M_valB[7:0]}};
                end
                2'b01: begin
                    dmem.dmem_wstrb = M_valE[1] ? 4'b1100 : 4'b0011;
                    dmem.dmem_wdata = {(XLEN/16){M_valB[15:0]}};
                end
                default: dmem.dmem_wstrb = 4'b1111;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: ALU pass-through, load/store
// sequencing, W backpressure, misaligned access and reset during a request.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_to_m_valid;
    logic        m_allow_in;
    logic        m_to_w_valid;
    logic        w_allow_in;
    logic [6:0]  E_opcode;
    logic [2:0]  E_funct3;
    logic [4:0]  E_rd;
    logic [31:0] E_valE, E_valB, E_default_pc, E_cur_pc, E_instr, E_pred_pc;
    logic [6:0]  M_opcode;
    logic [4:0]  M_rd;
    logic [31:0] M_valE, M_default_pc, M_cur_pc, M_instr, M_pred_pc;
    logic [31:0] m_valM;
    logic        M_misalign;

    int errors = 0;
    int checks = 0;
    int req_cycles = 0;
    int accepts = 0;
    int req_base = 0;
    int acc_base = 0;

    memory_access_stage_if #(.XLEN(32)) dmem_bus ();

    memory_access_stage #(.XLEN(32), .OP_LOAD(7'h03), .OP_STORE(7'h23)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
        .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
        .E_opcode(E_opcode), .E_funct3(E_funct3), .E_rd(E_rd),
        .E_valE(E_valE), .E_valB(E_valB), .E_default_pc(E_default_pc),
        .E_cur_pc(E_cur_pc), .E_instr(E_instr), .E_pred_pc(E_pred_pc),
        .M_opcode(M_opcode), .M_rd(M_rd), .M_valE(M_valE),
        .M_default_pc(M_default_pc), .M_cur_pc(M_cur_pc),
        .M_instr(M_instr), .M_pred_pc(M_pred_pc),
        .m_valM(m_valM), .M_misalign(M_misalign),
        .dmem(dmem_bus)
    );

    always #5 clk = ~clk;

    // Request-cycle and accepted-request counters seen at each rising edge
    always @(posedge clk) begin
        if (rst_n && dmem_bus.dmem_req) begin
            req_cycles++;
            if (dmem_bus.dmem_ready) accepts++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] va, input logic [31:0] vb);
        e_to_m_valid = v;
        E_opcode     = op;
        E_funct3     = f3;
        E_rd         = rd;
        E_valE       = va;
        E_valB       = vb;
        E_cur_pc     = 32'h0000_8000 + va;
        E_default_pc = 32'h0000_8004 + va;
        E_instr      = 32'h00C0_0013;
        E_pred_pc    = 32'h0000_0040;
    endtask

    task automatic snap();
        req_base = req_cycles;
        acc_base = accepts;
    endtask

    initial begin
        rst_n = 1'b0;
        w_allow_in = 1'b0;
        dmem_bus.dmem_ready  = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = '0;
        drive_e(1'b0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0);

        // Reset state
        @(negedge clk);
        chk("rst_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("rst_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        chk("rst_valE", M_valE, 32'h0);
        chk("rst_valM", m_valM, 32'h0);
        chk("rst_allow", {31'b0, m_allow_in}, 32'd1);
        rst_n = 1'b1;

        // Three back-to-back ALU ops
        drive_e(1'b1, 7'h33, 3'd0, 5'd5, 32'h1234, 32'h0);
        w_allow_in = 1'b1;
        #1 chk("alu_allow", {31'b0, m_allow_in}, 32'd1);
        @(negedge clk);
        chk("alu1_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("alu1_valE", M_valE, 32'h1234);
        chk("alu1_rd", {27'b0, M_rd}, 32'd5);
        chk("alu1_opc", {25'b0, M_opcode}, 32'h33);
        chk("alu1_curpc", M_cur_pc, 32'h0000_9234);
        chk("alu1_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        drive_e(1'b1, 7'h33, 3'd0, 5'd6, 32'h2222, 32'h0);
        @(negedge clk);
        chk("alu2_valE", M_valE, 32'h2222);
        chk("alu2_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        drive_e(1'b1, 7'h33, 3'd0, 5'd7, 32'h3333, 32'h0);
        @(negedge clk);
        chk("alu3_valE", M_valE, 32'h3333);
        chk("alu3_wvalid", {31'b0, m_to_w_valid}, 32'd1);

        // LB 0x1003: ready after two request cycles, stray rvalid in the ready cycle
        snap();
        drive_e(1'b1, 7'h03, 3'd0, 5'd8, 32'h1003, 32'h0);
        @(negedge clk);
        chk("lb_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("lb_we", {31'b0, dmem_bus.dmem_we}, 32'd0);
        chk("lb_addr", dmem_bus.dmem_addr, 32'h1000);
        chk("lb_wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'h0);
        chk("lb_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        drive_e(1'b1, 7'h33, 3'd0, 5'd9, 32'h5555, 32'h0);
        #1 chk("lb_stall", {31'b0, m_allow_in}, 32'd0);
        @(negedge clk);
        chk("lb_req_hold", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("lb_addr_hold", dmem_bus.dmem_addr, 32'h1000);
        dmem_bus.dmem_ready  = 1'b1;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_bus.dmem_ready  = 1'b0;
        chk("lb_wait_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("lb_wait_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        chk("lb_wait_valM", m_valM, 32'h0);
        chk("lb_wait_stall", {31'b0, m_allow_in}, 32'd0);
        dmem_bus.dmem_rdata = 32'h80FF_0011;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = '0;
        chk("lb_done_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("lb_valM", m_valM, 32'hFFFF_FF80);
        chk("lb_done_allow", {31'b0, m_allow_in}, 32'd1);
        chk("lb_req_cycles", req_cycles - req_base, 32'd2);
        chk("lb_accepts", accepts - acc_base, 32'd1);
        @(negedge clk);
        chk("after_lb_valE", M_valE, 32'h5555);
        chk("after_lb_valM", m_valM, 32'h0);
        chk("after_lb_wvalid", {31'b0, m_to_w_valid}, 32'd1);

        // SH 0x2002, then SB 0x2001 captured on the SH handoff edge
        snap();
        drive_e(1'b1, 7'h23, 3'd1, 5'd0, 32'h2002, 32'hABCD_1234);
        @(negedge clk);
        chk("sh_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("sh_we", {31'b0, dmem_bus.dmem_we}, 32'd1);
        chk("sh_addr", dmem_bus.dmem_addr, 32'h2000);
        chk("sh_wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'hC);
        chk("sh_wdata", dmem_bus.dmem_wdata, 32'h1234_1234);
        chk("sh_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        dmem_bus.dmem_ready = 1'b1;
        drive_e(1'b1, 7'h23, 3'd0, 5'd0, 32'h2001, 32'h0000_00A5);
        @(negedge clk);
        dmem_bus.dmem_ready = 1'b0;
        chk("sh_done_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("sh_done_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("sh_done_allow", {31'b0, m_allow_in}, 32'd1);
        chk("sh_req_cycles", req_cycles - req_base, 32'd1);
        @(negedge clk);
        chk("sb_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("sb_wstrb", {28'b0, dmem_bus.dmem_wstrb}, 32'h2);
        chk("sb_wdata", dmem_bus.dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dmem_bus.dmem_addr, 32'h2000);
        chk("sb_valE", M_valE, 32'h2001);
        drive_e(1'b0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0);
        dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_ready = 1'b0;
        chk("sb_done_wvalid", {31'b0, m_to_w_valid}, 32'd1);

        // LHU 0x1002 with W stalled for three cycles
        snap();
        drive_e(1'b1, 7'h03, 3'd5, 5'd10, 32'h1002, 32'h0);
        @(negedge clk);
        chk("lhu_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("lhu_addr", dmem_bus.dmem_addr, 32'h1000);
        drive_e(1'b0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0);
        dmem_bus.dmem_ready = 1'b1;
        w_allow_in = 1'b0;
        @(negedge clk);
        dmem_bus.dmem_ready  = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h8001_7FFF;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = '0;
        chk("lhu_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("lhu_valM", m_valM, 32'h0000_8001);
        chk("lhu_stall", {31'b0, m_allow_in}, 32'd0);
        chk("lhu_req0", {31'b0, dmem_bus.dmem_req}, 32'd0);
        @(negedge clk);
        chk("lhu_hold1_valM", m_valM, 32'h0000_8001);
        chk("lhu_hold1_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("lhu_hold1_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        @(negedge clk);
        chk("lhu_hold2_valM", m_valM, 32'h0000_8001);
        chk("lhu_hold2_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("lhu_req_cycles", req_cycles - req_base, 32'd1);
        chk("lhu_accepts", accepts - acc_base, 32'd1);
        w_allow_in = 1'b1;
        #1 chk("lhu_release", {31'b0, m_allow_in}, 32'd1);

        // Misaligned LW 0x1001
        snap();
        drive_e(1'b1, 7'h03, 3'd2, 5'd11, 32'h1001, 32'h0);
        @(negedge clk);
        drive_e(1'b0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0);
        chk("mis_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("mis_flag", {31'b0, M_misalign}, 32'd1);
        chk("mis_wvalid", {31'b0, m_to_w_valid}, 32'd1);
        chk("mis_valM", m_valM, 32'h0);
        chk("mis_valE", M_valE, 32'h1001);
        @(negedge clk);
        chk("mis_drain", {31'b0, m_to_w_valid}, 32'd0);
        chk("mis_no_req", req_cycles - req_base, 32'd0);

        // Reset while a LW request waits for ready
        drive_e(1'b1, 7'h03, 3'd2, 5'd12, 32'h3000, 32'h0);
        @(negedge clk);
        drive_e(1'b0, 7'h00, 3'd0, 5'd0, 32'h0, 32'h0);
        chk("lw_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
        chk("lw_aligned", {31'b0, M_misalign}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstreq_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("rstreq_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        chk("rstreq_valE", M_valE, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("post_rst_wvalid", {31'b0, m_to_w_valid}, 32'd0);
        chk("post_rst_allow", {31'b0, m_allow_in}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
